aegis_block_packer: RTL
=======================

Name: aegis_block_packer

Overview:
- Streaming front-end for the AEGIS-256 core. Accepts a ready/valid stream of IN_W-bit beats carrying associated data (AD) and then message data.
- Packs the beats into BLK_W-bit blocks and zero-pads each partial final block.
- Tags every block as AD or message, with segment-end and packet-end flags.
- Accumulates adlen/msglen in bits, so the core sees whole blocks plus ready-made length fields.

Parameters:
- IN_W, 32, input beat width in bits; multiple of 8, divides BLK_W, 8..BLK_W
- BLK_W, 128, output block width in bits (AEGIS block)
- LEN_W, 64, width of the adlen/msglen outputs in bits
- Derived: NB = IN_W/8 (bytes per beat); BEATS = BLK_W/IN_W; KW = $clog2(NB)+1

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- s_valid  in  1  input beat valid
- s_ready  out  1  input beat accepted when s_valid & s_ready
- s_data  in  IN_W  beat data; byte j at bits [8j+7:8j]
- s_keep  in  KW  valid bytes in beat (1..NB); sampled only when s_last=1, otherwise NB
- s_is_ad  in  1  1 = AD beat, 0 = message beat
- s_last  in  1  last beat of the current segment
- s_eom  in  1  last beat of the packet; legal only with s_last=1 and s_is_ad=0
- m_valid  out  1  output block valid
- m_ready  in  1  output block consumed when m_valid & m_ready
- m_block  out  BLK_W  packed block; beat k at bits [k*IN_W +: IN_W]; unused bytes 0
- m_bytes  out  $clog2(BLK_W/8)+1  valid bytes in block (1..BLK_W/8)
- m_is_ad  out  1  block type
- m_last  out  1  last block of segment
- m_eop  out  1  last block of packet
- adlen  out  LEN_W  packet AD length in bits; valid while m_eop & m_valid, held until next packet's first block
- msglen  out  LEN_W  packet message length in bits; same timing as adlen
- err  out  1  one-cycle pulse on protocol violation

Behaviour:
- Reset, synchronous on clk when reset=1:
  - All outputs 0; s_ready 0 during reset, 1 the cycle after.
  - Accumulator, byte counters and FSM are cleared.
  - Reset mid-block discards all partial data; no residue appears in later blocks.
- FSM states and transitions:
  - IDLE (start of packet): AD beat -> AD; message beat -> MSG.
  - AD: AD beat with s_last -> MSG_WAIT; message beat without a preceding s_last -> treated as implicit AD end, block flushed, -> MSG.
  - MSG_WAIT: message beat -> MSG; AD beat -> err, beat dropped.
  - MSG: AD beat -> err, beat dropped, state unchanged; s_eom -> IDLE.
- Packing:
  - Accepted beat k (0..BEATS-1) is written at bits [k*IN_W +: IN_W].
  - On s_last, bytes at index >= s_keep are forced to 0.
  - s_keep of 0 or greater than NB is treated as NB.
- Block completion: a block completes on the BEATS-th beat or on any s_last beat (early flush, remaining bytes 0). m_bytes = sum of valid bytes in the block.
- Buffering and handshake:
  - One output register plus one full-block accumulator holding register.
  - A completing beat loads the output register directly if it is empty or being drained (m_ready=1) that cycle. Otherwise the completed block is held in the accumulator and acc_full is set.
  - s_ready = !acc_full.
  - m_valid rises the cycle after the completing beat is accepted; latency 1.
  - Sustained throughput is one beat per cycle when m_ready=1.
  - Output fields are stable while m_valid & !m_ready.
- Lengths:
  - Byte counters per segment increment by the valid bytes of each accepted, non-dropped beat.
  - adlen = ad_bytes<<3 and msglen = msg_bytes<<3, modulo 2^LEN_W.
  - Both are latched into the output with the m_eop block; counters clear on packet end.
  - Zero-length AD gives adlen=0. The message must contain at least 1 byte.
- Simultaneous events:
  - An output drain and a new completing beat in the same cycle: the new block loads, no bubble.
  - acc_full clears when the output drains; the held block moves to the output register the same edge.
- Errors:
  - AD beat in MSG_WAIT or MSG: err pulses 1 cycle, beat dropped.
  - s_eom on an AD beat: err pulses, s_eom ignored, beat processed as AD.

Test Plan (IN_W=32, BLK_W=128):
1. AD 3 beats (last keep=4), then message 4 beats (eom) -> AD block m_bytes=12, bits[127:96]=0, m_is_ad=1, m_last=1; message block m_bytes=16, m_eop=1; adlen=96, msglen=128.
2. Message only: 1 beat 0xAABBCCDD, keep=1, last, eom -> m_block=0x...00DD, m_bytes=1, m_eop=1, adlen=0, msglen=8.
3. m_ready=0, 12 back-to-back beats -> exactly 8 accepted, then s_ready=0. After m_ready=1, 3 blocks arrive in order, no loss or duplication.
4. Message beat then AD beat -> err pulse 1 cycle, AD beat dropped, msglen excludes its bytes, packet completes normally.
5. reset asserted after 2 beats of a block -> outputs 0 next cycle. The next packet's first block contains only new data; lengths count only the new packet.
6. m_ready=1, 8 continuous message beats (last+eom on 8th) -> s_ready stays 1, m_valid in the cycles after beats 4 and 8, second block m_eop=1, msglen=256.

Source files
------------

// File: rtl/aegis_block_packer_if.sv
// Stream-in / block-out bundle for the AEGIS-256 block packer.
// The packer uses the slave view; the surrounding environment uses the master view.
interface aegis_block_packer_if #(
  parameter int IN_W  = 32,
  parameter int BLK_W = 128,
  parameter int LEN_W = 64
) ();
  localparam int NB = IN_W / 8;
  localparam int KW = $clog2(NB) + 1;
  localparam int BW = $clog2(BLK_W / 8) + 1;

  logic              s_valid;
  logic              s_ready;
  logic [IN_W-1:0]   s_data;
  logic [KW-1:0]     s_keep;
  logic              s_is_ad;
  logic              s_last;
  logic              s_eom;

  logic              m_valid;
  logic              m_ready;
  logic [BLK_W-1:0]  m_block;
  logic [BW-1:0]     m_bytes;
  logic              m_is_ad;
  logic              m_last;
  logic              m_eop;
  logic [LEN_W-1:0]  adlen;
  logic [LEN_W-1:0]  msglen;
  logic              err;

  modport master (
    output s_valid, s_data, s_keep, s_is_ad, s_last, s_eom, m_ready,
    input  s_ready, m_valid, m_block, m_bytes, m_is_ad, m_last, m_eop,
           adlen, msglen, err
  );

  modport slave (
    input  s_valid, s_data, s_keep, s_is_ad, s_last, s_eom, m_ready,
    output s_ready, m_valid, m_block, m_bytes, m_is_ad, m_last, m_eop,
           adlen, msglen, err
  );
endinterface

// File: rtl/aegis_block_packer.sv
// Packs AD/message beats into zero-padded AEGIS blocks with segment/packet flags
// and bit-length fields; one output register plus one held block in the accumulator.
module aegis_block_packer #(
  parameter int IN_W  = 32,
  parameter int BLK_W = 128,
  parameter int LEN_W = 64
) (
  input  logic               clk,
  input  logic               reset,
  aegis_block_packer_if.slave bus
);
  localparam int NB    = IN_W / 8;
  localparam int BEATS = BLK_W / IN_W;
  localparam int KW    = $clog2(NB) + 1;
  localparam int BW    = $clog2(BLK_W / 8) + 1;
  localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_AD, S_MSG_WAIT, S_MSG} state_t;

  state_t            r_state, w_next;

  logic [BLK_W-1:0]  r_acc;
  logic [BW-1:0]     r_acc_bytes;
  logic [CW-1:0]     r_cnt;
  logic              r_acc_full;
  logic              r_hold_ad, r_hold_last, r_hold_eop;
  logic [LEN_W-1:0]  r_ad_bytes, r_msg_bytes;
  logic [LEN_W-1:0]  r_pend_adlen, r_pend_msglen;

  logic              r_m_valid, r_m_is_ad, r_m_last, r_m_eop, r_err;
  logic [BLK_W-1:0]  r_m_block;
  logic [BW-1:0]     r_m_bytes;
  logic [LEN_W-1:0]  r_adlen, r_msglen;

  logic              w_flush, w_ready, w_accept, w_drop, w_beat, w_eom, w_last;
  logic              w_cmp, w_cmp_ad, w_cmp_last, w_cmp_eop, w_out_free, w_err;
  logic [KW-1:0]     w_keep;
  logic [IN_W-1:0]   w_data;
  logic [BLK_W-1:0]  w_cmp_block;
  logic [BW-1:0]     w_cmp_bytes;
  logic [LEN_W-1:0]  w_ad_tot, w_msg_tot;

  // A message beat arriving while AD data sits half-packed first flushes that
  // AD block (stalling the beat one cycle), so the two types never share a block.
  always_comb begin
    // NOTE: every comb output gets a default first so no path can infer a latch.
    w_next  = r_state;
    w_flush = bus.s_valid & ~bus.s_is_ad & (r_state == S_AD) & (r_cnt != '0) & ~r_acc_full;
    w_ready = ~reset & ~r_acc_full & ~w_flush;
    w_accept = bus.s_valid & w_ready;
    w_drop  = bus.s_is_ad & ((r_state == S_MSG_WAIT) | (r_state == S_MSG));
    w_beat  = w_accept & ~w_drop;
    w_eom   = bus.s_eom & ~bus.s_is_ad;
    w_last  = bus.s_last | w_eom;
    w_err   = w_accept & bus.s_is_ad & (w_drop | bus.s_eom);

    if (w_flush) begin
      w_next = S_MSG_WAIT;
    end else if (w_beat) begin
      if (bus.s_is_ad) w_next = bus.s_last ? S_MSG_WAIT : S_AD;
      else             w_next = w_eom ? S_IDLE : S_MSG;
    end
  end

  always_comb begin
    w_keep = KW'(NB);
    if (bus.s_last && bus.s_keep != '0 && bus.s_keep <= KW'(NB)) w_keep = bus.s_keep;

    w_data = '0;
    for (int j = 0; j < NB; j++) begin
      if (j < int'(w_keep)) w_data[8*j +: 8] = bus.s_data[8*j +: 8];
    end

    w_cmp       = w_flush | (w_beat & (w_last | (r_cnt == CW'(BEATS - 1))));
    w_cmp_block = w_flush ? r_acc : (r_acc | (BLK_W'(w_data) << (int'(r_cnt) * IN_W)));
    w_cmp_bytes = r_acc_bytes + (w_flush ? '0 : BW'(w_keep));
    w_cmp_ad    = w_flush | bus.s_is_ad;
    w_cmp_last  = w_flush | w_last;
    w_cmp_eop   = ~w_flush & w_eom;

    w_ad_tot    = r_ad_bytes  + ((w_beat &  bus.s_is_ad) ? LEN_W'(w_keep) : '0);
    w_msg_tot   = r_msg_bytes + ((w_beat & ~bus.s_is_ad) ? LEN_W'(w_keep) : '0);
    w_out_free  = ~r_m_valid | bus.m_ready;
  end

  always_ff @(posedge clk) begin
    // NOTE: all sequential state uses <= so every register samples pre-edge values.
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the accumulator is cleared too; packing ORs beats into it, so stale bits would leak.
      r_acc        <= '0;
      r_acc_bytes  <= '0;
      r_cnt        <= '0;
      r_acc_full   <= 1'b0;
      r_hold_ad    <= 1'b0;
      r_hold_last  <= 1'b0;
      r_hold_eop   <= 1'b0;
      r_ad_bytes   <= '0;
      r_msg_bytes  <= '0;
      r_pend_adlen <= '0;
      r_pend_msglen <= '0;
      r_m_valid    <= 1'b0;
      r_m_block    <= '0;
      r_m_bytes    <= '0;
      r_m_is_ad    <= 1'b0;
      r_m_last     <= 1'b0;
      r_m_eop      <= 1'b0;
      r_adlen      <= '0;
      r_msglen     <= '0;
      r_err        <= 1'b0;
    end else begin
      r_err <= w_err;

      if (r_acc_full && w_out_free) begin
        r_m_valid <= 1'b1;
        r_m_block <= r_acc;
        r_m_bytes <= r_acc_bytes;
        r_m_is_ad <= r_hold_ad;
        r_m_last  <= r_hold_last;
        r_m_eop   <= r_hold_eop;
        if (r_hold_eop) begin
          r_adlen  <= r_pend_adlen;
          r_msglen <= r_pend_msglen;
        end
      end else if (w_cmp && w_out_free) begin
        r_m_valid <= 1'b1;
        r_m_block <= w_cmp_block;
        r_m_bytes <= w_cmp_bytes;
        r_m_is_ad <= w_cmp_ad;
        r_m_last  <= w_cmp_last;
        r_m_eop   <= w_cmp_eop;
        if (w_cmp_eop) begin
          r_adlen  <= w_ad_tot << 3;
          r_msglen <= w_msg_tot << 3;
        end
      end else if (bus.m_ready) begin
        r_m_valid <= 1'b0;
      end

      if (r_acc_full) begin
        if (w_out_free) begin
          r_acc       <= '0;
          r_acc_bytes <= '0;
          r_acc_full  <= 1'b0;
        end
      end else if (w_cmp) begin
        r_cnt <= '0;
        if (w_out_free) begin
          r_acc       <= '0;
          r_acc_bytes <= '0;
        end else begin
          r_acc       <= w_cmp_block;
          r_acc_bytes <= w_cmp_bytes;
          r_acc_full  <= 1'b1;
          r_hold_ad   <= w_cmp_ad;
          r_hold_last <= w_cmp_last;
          r_hold_eop  <= w_cmp_eop;
        end
      end else if (w_beat) begin
        r_acc       <= w_cmp_block;
        r_acc_bytes <= w_cmp_bytes;
        r_cnt       <= r_cnt + CW'(1);
      end

      if (w_beat) begin
        if (w_eom) begin
          r_ad_bytes    <= '0;
          r_msg_bytes   <= '0;
          r_pend_adlen  <= w_ad_tot << 3;
          r_pend_msglen <= w_msg_tot << 3;
        end else begin
          r_ad_bytes  <= w_ad_tot;
          r_msg_bytes <= w_msg_tot;
        end
      end
    end
  end

  assign bus.s_ready = w_ready;
  assign bus.m_valid = r_m_valid;
  assign bus.m_block = r_m_block;
  assign bus.m_bytes = r_m_bytes;
  assign bus.m_is_ad = r_m_is_ad;
  assign bus.m_last  = r_m_last;
  assign bus.m_eop   = r_m_eop;
  assign bus.adlen   = r_adlen;
  assign bus.msglen  = r_msglen;
  assign bus.err     = r_err;
endmodule
